// File: rtl/led_green_fader_pkg.sv
// Shared constants and types for the green-LED PWM/fade block.
package led_green_fader_pkg;

    localparam int unsigned LEVEL_W = 8;
    localparam int unsigned HOLD_W  = 16;
    localparam int unsigned DATA_W  = 32;

    localparam logic [1:0] ADDR_DUTY   = 2'd0;
    localparam logic [1:0] ADDR_HOLD   = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [LEVEL_W-1:0] DUTY_RST = 8'hFF;
    localparam logic [HOLD_W-1:0]  HOLD_RST = 16'h0000;

    typedef enum logic [1:0] {
        FADE_IDLE = 2'd0,
        FADE_UP   = 2'd1,
        FADE_TOP  = 2'd2,
        FADE_DOWN = 2'd3
    } fade_state_e;

    // STATUS register layout as seen on readdata
    typedef struct packed {
        logic [21:0]          rsvd;
        fade_state_e          state;
        logic [LEVEL_W-1:0]   level;
    } status_t;

endpackage

// File: rtl/led_fade_tick_gen.sv
// Fade prescaler: counts 0..PRESCALE-1 and flags the wrap cycle.
module led_fade_tick_gen #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_c
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick_c = (cnt == CNT_MAX);

endmodule

// File: rtl/led_green_fader.sv
// Green-LED driver: registered PIO pattern gated by PWM brightness and an
// optional triangular breathing envelope, configured over Avalon-MM.
module led_green_fader
    import led_green_fader_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned WIDTH    = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  pattern_in,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  led_o
);

    logic [LEVEL_W-1:0] duty;
    logic [HOLD_W-1:0]  hold;
    logic               fade_en;

    logic [WIDTH-1:0]   pattern_q;
    logic [LEVEL_W-1:0] pwm_cnt;
    logic               lit_c;
    logic               tick_c;

    fade_state_e        state, state_nxt;
    logic [LEVEL_W-1:0] level, level_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
    logic [LEVEL_W:0]   up_sum;

    led_fade_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .tick_c (tick_c)
    );

    // Register file writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty    <= DUTY_RST;
            hold    <= HOLD_RST;
            fade_en <= 1'b0;
        end else if (chipselect && !write_n) begin
            case (address)
                ADDR_DUTY: duty    <= writedata[LEVEL_W-1:0];
                ADDR_HOLD: hold    <= writedata[HOLD_W-1:0];
                ADDR_CTRL: fade_en <= writedata[0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        status_t st;
        st       = '{rsvd: '0, state: state, level: level};
        readdata = '0;
        case (address)
            ADDR_DUTY:   readdata = DATA_W'(duty);
            ADDR_HOLD:   readdata = DATA_W'(hold);
            ADDR_CTRL:   readdata = DATA_W'(fade_en);
            ADDR_STATUS: readdata = st;
            default:     readdata = '0;
        endcase
    end

    // Full scale is solid on rather than 255/256
    assign lit_c = (level == 8'hFF) || (pwm_cnt < level);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= '0;
            pwm_cnt   <= '0;
            led_o     <= '0;
        end else begin
            pattern_q <= pattern_in;
            pwm_cnt   <= pwm_cnt + LEVEL_W'(1);
            led_o     <= pattern_q & {WIDTH{lit_c}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FADE_IDLE;
            level    <= DUTY_RST;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            level    <= level_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Fade envelope; the bottom dwell shares FADE_DOWN with level at zero
    always_comb begin
        state_nxt    = state;
        level_nxt    = level;
        hold_cnt_nxt = hold_cnt;
        up_sum       = {1'b0, level} + 9'd1;

        if (!fade_en) begin
            state_nxt = FADE_IDLE;
            level_nxt = duty;
        end else begin
            case (state)
                FADE_IDLE: begin
                    state_nxt    = FADE_UP;
                    level_nxt    = '0;
                    hold_cnt_nxt = '0;
                end
                FADE_UP: if (tick_c) begin
                    if (up_sum >= {1'b0, duty}) begin
                        state_nxt    = FADE_TOP;
                        level_nxt    = duty;
                        hold_cnt_nxt = '0;
                    end else begin
                        level_nxt = up_sum[LEVEL_W-1:0];
                    end
                end
                FADE_TOP: if (tick_c) begin
                    if (hold_cnt >= hold) begin
                        state_nxt    = FADE_DOWN;
                        level_nxt    = (level == '0) ? '0 : level - LEVEL_W'(1);
                        hold_cnt_nxt = '0;
                    end else begin
                        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
                FADE_DOWN: if (tick_c) begin
                    if (level != '0) begin
                        level_nxt    = level - LEVEL_W'(1);
                        hold_cnt_nxt = '0;
                    end else if (hold_cnt >= hold) begin
                        state_nxt = FADE_UP;
                        level_nxt = (duty == '0) ? '0 : LEVEL_W'(1);
                    end else begin
                        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
                default: state_nxt = FADE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_green_fader.sv
// Directed + random bench for led_green_fader against a cycle-level reference model.
module tb_led_green_fader;

    localparam int unsigned P = 4;
    localparam int unsigned W = 9;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] pattern_in;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] led_o;

    always #5 clk = ~clk;

    led_green_fader #(.PRESCALE(P), .WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pattern_in (pattern_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_o      (led_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phases of the breathing envelope, bottom dwell separate
    localparam int PH_IDLE = 0, PH_RISE = 1, PH_TOP = 2, PH_FALL = 3, PH_BOTTOM = 4;
    int m_duty, m_hold, m_fade, m_pq, m_led, m_pwm, m_pre, m_level, m_phase, m_cnt;
    bit m_tick;

    task automatic m_reset();
        m_duty = 255; m_hold = 0; m_fade = 0; m_pq = 0; m_led = 0;
        m_pwm = 0; m_pre = 0; m_level = 255; m_phase = PH_IDLE; m_cnt = 0;
        m_tick = 1'b0;
    endtask

    function automatic int m_code();
        return (m_phase == PH_BOTTOM) ? 3 : m_phase;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0:       return 32'(m_duty);
            1:       return 32'(m_hold);
            2:       return 32'(m_fade);
            default: return 32'(m_code() * 256 + m_level);
        endcase
    endfunction

    task automatic m_advance(input bit rst, input bit wr, input int a,
                             input logic [31:0] wd, input int pat);
        bit tick, lit;
        if (rst) begin
            m_reset();
            return;
        end
        tick  = (m_pre == int'(P) - 1);
        lit   = (m_level == 255) || (m_pwm < m_level);
        m_led = lit ? m_pq : 0;
        m_pq  = pat;
        m_pwm = (m_pwm + 1) % 256;
        m_pre = (m_pre + 1) % int'(P);
        if (m_fade == 0) begin
            m_phase = PH_IDLE;
            m_level = m_duty;
        end else if (m_phase == PH_IDLE) begin
            m_phase = PH_RISE; m_level = 0; m_cnt = 0;
        end else if (tick) begin
            case (m_phase)
                PH_RISE: if (m_level + 1 >= m_duty) begin
                    m_level = m_duty; m_phase = PH_TOP; m_cnt = 0;
                end else m_level++;
                PH_TOP: if (m_cnt >= m_hold) begin
                    m_level = (m_level > 0) ? m_level - 1 : 0;
                    m_phase = (m_level == 0) ? PH_BOTTOM : PH_FALL;
                    m_cnt = 0;
                end else m_cnt++;
                PH_FALL: begin
                    m_level--;
                    if (m_level == 0) begin m_phase = PH_BOTTOM; m_cnt = 0; end
                end
                default: if (m_cnt >= m_hold) begin
                    m_phase = PH_RISE; m_level = (m_duty < 1) ? m_duty : 1;
                end else m_cnt++;
            endcase
        end
        if (wr) begin
            case (a)
                0: m_duty = int'(wd & 32'hFF);
                1: m_hold = int'(wd & 32'hFFFF);
                2: m_fade = int'(wd & 32'h1);
                default: ;
            endcase
        end
        m_tick = tick;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_assert++;
        n_fail++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // One clock: sample inputs, clock DUT and model, then compare
    task automatic step();
        bit rst, wr;
        int a, pat;
        logic [31:0] wd;
        rst = reset; wr = chipselect && !write_n; a = int'(address);
        wd = writedata; pat = int'(pattern_in);
        @(posedge clk);
        m_advance(rst, wr, a, wd, pat);
        #1;
        chk("led_o", 32'(led_o), 32'(m_led));
        chk("readdata", readdata, m_read(int'(address)));
    endtask

    task automatic wr_reg(input int a, input logic [31:0] d);
        address = 2'(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            step();
            ok = m_tick;
        end
    endtask

    int exp_lvl[12]  = '{0, 1, 2, 3, 3, 3, 2, 1, 0, 0, 0, 1};
    int exp_code[12] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 1};

    initial begin
        bit ok;
        int cnt, r;
        m_reset();
        reset = 1'b1; pattern_in = '0; address = '0; chipselect = 1'b0;
        write_n = 1'b1; writedata = '0;
        #2;
        for (int i = 0; i < 3; i++) step();
        chk("reset_led", 32'(led_o), 32'h0);
        address = 2'd0; #1; chk("reset_duty", readdata, 32'h0000_00FF);
        address = 2'd1; #1; chk("reset_hold", readdata, 32'h0);
        address = 2'd2; #1; chk("reset_ctrl", readdata, 32'h0);
        address = 2'd3; #1; chk("reset_status", readdata, 32'h0000_00FF);

        // Full brightness idle: solid on from the second edge
        reset = 1'b0; pattern_in = 9'h1FF;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i >= 1) chk("idle_full", 32'(led_o), 32'h1FF);
        end

        // PWM duty 0x40 -> 64 of 256 cycles lit
        wr_reg(0, 32'h40); pattern_in = 9'h001;
        for (int i = 0; i < 4; i++) step();
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            cnt += int'(led_o[0]);
        end
        chk("pwm_duty", 32'(cnt), 32'd64);

        // Fade cycle DUTY=3 HOLD=2
        wr_reg(0, 3); wr_reg(1, 2); wr_reg(2, 1);
        address = 2'd3;
        step();
        chk("fade_seq0", readdata, 32'(exp_code[0] * 256 + exp_lvl[0]));
        for (int k = 1; k < 12; k++) begin
            wait_tick(ok);
            if (!ok) timeout("fade_tick");
            chk("fade_seq", readdata, 32'(exp_code[k] * 256 + exp_lvl[k]));
        end

        // DUTY lowered mid-ramp
        wr_reg(2, 0); wr_reg(0, 32'h20); wr_reg(1, 0); wr_reg(2, 1);
        address = 2'd3; ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            ok = (readdata == 32'h105);
        end
        if (!ok) timeout("reach_level5");
        wr_reg(0, 2);
        address = 2'd3;
        wait_tick(ok);
        if (!ok) timeout("clamp_tick");
        chk("clamp_top", readdata, 32'h202);

        // STATUS is read-only; HOLD keeps 16 bits
        wr_reg(3, 32'hFFFF_FFFF);
        chk("status_ro", readdata, m_read(3));
        wr_reg(1, 32'h1ABCD);
        address = 2'd1; #1;
        chk("hold_rb", readdata, 32'h0000_ABCD);

        // Random register traffic and patterns against the model
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 15));
            case (r)
                0: wr_reg(0, ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 12)));
                1: wr_reg(0, $urandom);
                2: wr_reg(1, $urandom & 32'hFFFF_0003);
                3: wr_reg(2, $urandom);
                4: begin pattern_in = W'($urandom); step(); end
                default: begin address = 2'($urandom); step(); end
            endcase
        end

        // Async reset while falling at level 0x80
        wr_reg(2, 0); wr_reg(0, 32'h81); wr_reg(1, 0); wr_reg(2, 1);
        pattern_in = 9'h1FF; address = 2'd3; ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            step();
            ok = (readdata == 32'h380);
        end
        if (!ok) timeout("reach_down80");
        #2 reset = 1'b1;
        #1;
        m_reset();
        chk("async_led", 32'(led_o), 32'h0);
        chk("async_status", readdata, 32'h0000_00FF);
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("post_reset_state", 32'(readdata[9:8]), 32'h0);
        address = 2'd2; #1;
        chk("post_reset_ctrl", readdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/led_green_fader.md
# led_green_fader

Downstream consumer of the green-LED PIO output port: takes the 9-bit pattern the PIO drives and turns it into the physical green-LED drive pins. It applies global PWM brightness and an optional triangular fade (breathing) envelope to every set pattern bit. Configuration comes through its own small Avalon-MM slave on the same system interconnect as the PIO.

## Interface
- PRESCALE, 50000: clk cycles per fade tick (1 ms at 50 MHz); legal range ≥ 2.
- WIDTH, 9: pattern/LED width.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- pattern_in  in  WIDTH  LED pattern from the PIO out_port.
- address  in  2  Avalon slave word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, zero-extended, combinational from registers.
- led_o  out  WIDTH  registered LED drive.

## Operation
- Register map, written when chipselect && !write_n:
  - 0 DUTY[7:0]: brightness target, reset 0xFF.
  - 1 HOLD[15:0]: ticks spent at top and at bottom of the fade, reset 0.
  - 2 CTRL[0]=fade_en, reset 0.
  - 3 STATUS: read-only, [7:0]=level, [9:8]=state code. Writes are ignored.
- Undefined bits read 0.
- Prescaler: counts 0..PRESCALE-1, wraps; tick asserts for one cycle on the wrap.
- PWM: 8-bit pwm_cnt free-runs 0..255, wrapping every 256 cycles.
  - lit = (pwm_cnt < level), except level==0xFF, which is always lit.
- Fade FSM, one step per tick:
  - IDLE (code 0): level = DUTY every cycle. Entered when fade_en=0.
  - On fade_en 0→1: go to UP with level=0, hold counter cleared.
  - UP (1): level+1 per tick. When level ≥ DUTY, set level=DUTY (clamp also covers DUTY lowered mid-ramp) and go to TOP.
  - TOP (2): count HOLD ticks, then go to DOWN. HOLD=0 means leave on the next tick.
  - DOWN (3): level−1 per tick. At 0, hold at 0 for HOLD ticks, then go to UP. Bottom dwell reuses code 3 with level=0.
  - fade_en→0 in any state: IDLE on the next cycle.
- DUTY=0 with fade_en=1: UP clamps immediately, LEDs stay dark, FSM keeps cycling.
- Output: led_o[i] = pattern_q[i] & lit, where pattern_q is pattern_in registered once.
- Arithmetic: level is 8-bit and never wraps (saturating clamps). The hold counter is 16-bit.

## Timing
- Reset values:
  - led_o=0, pattern_q=0, pwm_cnt=0, prescaler=0, level=0xFF, state=IDLE.
  - readdata reflects the reset register values.
- Register write takes effect on the clk edge where the write is sampled. Reads have zero wait states.
- Pattern latency: pattern_in change → led_o change after 2 edges (pattern_q, then led_o), for a lit PWM phase.
- Output latency from level/pwm_cnt to led_o: 1 cycle.
- Simultaneous tick and DUTY write: the new DUTY is used by the compare on the following tick, not the current one.
- reset mid-fade: immediate return to reset values; fade does not resume until fade_en is rewritten.

## Structure
- Shared package: register address constants (ADDR_DUTY..ADDR_STATUS), fade state enum with its 2-bit codes, and DUTY/HOLD reset constants.
- One natural sub-module: led_fade_tick_gen (prescaler, tick output). PWM, FSM and the register file stay in the top level.

## Test plan
- Reset then idle: led_o=0 after reset. With pattern_in=0x1FF and DUTY=0xFF, led_o=0x1FF continuously from cycle 2.
- PWM duty: DUTY=0x40, pattern_in=0x001. led_o[0] is high for exactly 64 of every 256 cycles; other bits stay 0.
- Fade cycle: PRESCALE=4, DUTY=3, HOLD=2, fade_en=1.
  - Level sequence on ticks: 0,1,2,3,3,3,2,1,0,0,0,1.
  - STATUS state codes follow 1→2→3→1.
- DUTY lowered mid-ramp: during UP at level 5, write DUTY=2. The next tick clamps level to 2 and enters TOP.
- Register access: write address 3 and read back STATUS unchanged. Write HOLD=0x1ABCD and read back 0x0000ABCD.
- Async reset mid-operation: assert reset while in DOWN with level=0x80, asynchronous to clk. led_o and STATUS are reset immediately; state=IDLE with fade_en=0 after release.
